blk_operand_sched: RTL and testbench

Sequencing controller for the 4-operand compute block. Four requesters load 4-bit operands into the block's four input slots through a round-robin req/ack arbiter. Once all enabled slots are filled, the controller launches the block, waits its fixed latency, and presents the captured result on a valid/ready output. The controller replaces the free-running strobe-per-slot loading at the top level.

---
 rtl/blk_sched_pkg.sv | 20 ++
 rtl/blk_operand_sched_rr_arb4.sv | 37 +++
 rtl/blk_operand_sched.sv | 182 ++++++++++++++++++
 tb/tb_blk_operand_sched.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blk_sched_pkg.sv
// -----------------------------------------------------------------------------
// blk_sched_pkg
// Shared types and sizing constants for the operand scheduler of the
// 4-operand compute block.
// -----------------------------------------------------------------------------
package blk_sched_pkg;

    localparam int unsigned N_REQ       = 4;   // requesters == operand slots
    localparam int unsigned IDX_W       = 2;   // slot index width
    localparam int unsigned DATA_W_DEF  = 4;   // default operand/result width
    localparam int unsigned LATENCY_DEF = 2;   // default block compute latency
    localparam int unsigned WCNT_W      = 4;   // latency counter, covers 1..15

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        WAIT    = 2'd1,
        RESULT  = 2'd2
    } state_e;

endpackage : blk_sched_pkg

// File: rtl/blk_operand_sched_rr_arb4.sv
// -----------------------------------------------------------------------------
// rr_arb4
// Combinational 4-way round-robin arbiter. The search starts at ptr and
// proceeds upward with wrap; the first eligible slot wins.
//
// Ports:
//   eligible  in  [3:0]  candidate slots
//   ptr       in  [1:0]  highest-priority slot this cycle
//   gnt_vld   out        a winner exists
//   gnt_idx   out [1:0]  index of the winner (don't-care when !gnt_vld)
// -----------------------------------------------------------------------------
module rr_arb4
    import blk_sched_pkg::*;
(
    input  logic [N_REQ-1:0] eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic             gnt_vld,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] idx;

    // Walk from lowest to highest priority so the nearest hit to ptr wins last.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = ptr;
        idx     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + IDX_W'(k);
            if (eligible[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule : rr_arb4

// File: rtl/blk_operand_sched.sv
// -----------------------------------------------------------------------------
// blk_operand_sched
// Sequencing controller for the 4-operand compute block. Requesters load
// operand slots through a round-robin req/ack arbiter; once every slot in
// slot_mask is filled the block is launched, its fixed latency is timed out,
// and the captured result is offered on a valid/ready port.
//
// Optional feature macro: BLKSCHED_COUNT_EN
//   defined   -> done_cnt counts result handshakes (wrapping)
//   undefined -> no counter, done_cnt tied to 0
//
// Ports:
//   clk        in                 clock
//   rst        in                 synchronous reset, active-high
//   req        in  [3:0]          per-requester load request (i -> slot i)
//   req_data   in  [4*DATA_W-1:0] packed operands, slot i at [i*DATA_W +: DATA_W]
//   ack        out [3:0]          one-cycle grant pulse
//   slot_mask  in  [3:0]          slots required for launch
//   opnd       out [4*DATA_W-1:0] operand registers driving block in1..in4
//   blk_res    in  [DATA_W-1:0]   block output
//   res        out [DATA_W-1:0]   captured result
//   res_valid  out                result available
//   res_ready  in                 consumer accepts result
//   busy       out                controller not in COLLECT
//   done_cnt   out [CNT_W-1:0]    completed-result counter
// -----------------------------------------------------------------------------
module blk_operand_sched
    import blk_sched_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned LATENCY = LATENCY_DEF,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        ack,
    input  logic [N_REQ-1:0]        slot_mask,
    output logic [N_REQ*DATA_W-1:0] opnd,
    input  logic [DATA_W-1:0]       blk_res,
    output logic [DATA_W-1:0]       res,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic                    busy,
    output logic [CNT_W-1:0]        done_cnt
);

    state_e                  state_q, state_d;
    logic [N_REQ-1:0]        filled_q, filled_d;
    logic [N_REQ-1:0]        act_mask_q, act_mask_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
    logic [N_REQ*DATA_W-1:0] opnd_d;
    logic [N_REQ-1:0]        ack_d;
    logic [DATA_W-1:0]       res_d;
    logic                    res_valid_d;
    logic                    busy_d;

    logic [N_REQ-1:0]        eligible_c;
    logic                    gnt_vld_c;
    logic [IDX_W-1:0]        gnt_idx_c;
    logic [N_REQ-1:0]        gnt_oh_c;
    logic                    launch_c;
    logic                    hs_c;

    // Slots already holding an operand are not re-granted.
    assign eligible_c = req & ~filled_q;

    rr_arb4 u_arb (
        .eligible (eligible_c),
        .ptr      (rr_ptr_q),
        .gnt_vld  (gnt_vld_c),
        .gnt_idx  (gnt_idx_c)
    );

    assign gnt_oh_c = gnt_vld_c ? (N_REQ'(1) << gnt_idx_c) : '0;

    // Launch looks at registered filled, so the final ack cycle can launch.
    assign launch_c = (slot_mask != '0) && ((filled_q & slot_mask) == slot_mask);
    assign hs_c     = (state_q == RESULT) && res_valid && res_ready;

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        filled_d    = filled_q;
        act_mask_d  = act_mask_q;
        rr_ptr_d    = rr_ptr_q;
        wcnt_d      = wcnt_q;
        opnd_d      = opnd;
        ack_d       = '0;
        res_d       = res;
        res_valid_d = res_valid;

        case (state_q)
            COLLECT: begin
                if (launch_c) begin
                    act_mask_d = slot_mask;
                    wcnt_d     = WCNT_W'(LATENCY);
                    state_d    = WAIT;
                end else if (gnt_vld_c) begin
                    ack_d    = gnt_oh_c;
                    filled_d = filled_q | gnt_oh_c;
                    rr_ptr_d = gnt_idx_c + IDX_W'(1);
                    for (int i = 0; i < N_REQ; i++) begin
                        if (gnt_oh_c[i]) begin
                            opnd_d[i*DATA_W +: DATA_W] = req_data[i*DATA_W +: DATA_W];
                        end
                    end
                end
            end
            WAIT: begin
                // <= guards against a zero count ever wrapping
                if (wcnt_q <= WCNT_W'(1)) begin
                    res_d       = blk_res;
                    res_valid_d = 1'b1;
                    wcnt_d      = '0;
                    state_d     = RESULT;
                end else begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end
            end
            RESULT: begin
                if (hs_c) begin
                    res_valid_d = 1'b0;
                    filled_d    = filled_q & ~act_mask_q;
                    state_d     = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase

        busy_d = (state_d != COLLECT);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= COLLECT;
            filled_q   <= '0;
            act_mask_q <= '0;
            rr_ptr_q   <= '0;
            wcnt_q     <= '0;
            opnd       <= '0;
            ack        <= '0;
            res        <= '0;
            res_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            filled_q   <= filled_d;
            act_mask_q <= act_mask_d;
            rr_ptr_q   <= rr_ptr_d;
            wcnt_q     <= wcnt_d;
            opnd       <= opnd_d;
            ack        <= ack_d;
            res        <= res_d;
            res_valid  <= res_valid_d;
            busy       <= busy_d;
        end
    end

`ifdef BLKSCHED_COUNT_EN
    logic [CNT_W-1:0] done_cnt_q;

    // Completed-result counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_cnt_q <= '0;
        end else if (hs_c) begin
            done_cnt_q <= done_cnt_q + CNT_W'(1);
        end
    end

    assign done_cnt = done_cnt_q;
`else
    assign done_cnt = '0;
`endif

endmodule : blk_operand_sched

// File: tb/tb_blk_operand_sched.sv
// -----------------------------------------------------------------------------
// tb_blk_operand_sched
// Self-checking bench for blk_operand_sched (DATA_W=4, LATENCY=2, CNT_W=8).
// -----------------------------------------------------------------------------
module tb_blk_operand_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] req_data = '0;
    logic [3:0]  ack;
    logic [3:0]  slot_mask = '0;
    logic [15:0] opnd;
    logic [3:0]  blk_res = '0;
    logic [3:0]  res;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        busy;
    logic [7:0]  done_cnt;

    int n_vec = 0;
    int n_err = 0;
    int hs_cnt = 0;
    int hs_base = 0;

    logic [3:0] sb[$];
    logic [3:0] sb_exp;

    typedef struct {
        logic [3:0] req;
        logic [3:0] mask;
        logic       rdy;
        logic [3:0] e_ack;
        logic       e_busy;
        logic       e_rv;
    } vec_t;

    vec_t tbl[9];

    blk_operand_sched #(
        .DATA_W  (4),
        .LATENCY (2),
        .CNT_W   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .slot_mask (slot_mask),
        .opnd      (opnd),
        .blk_res   (blk_res),
        .res       (res),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_done();
`ifdef BLKSCHED_COUNT_EN
        return 8'(hs_cnt - hs_base);
`else
        return 8'h00;
`endif
    endfunction

    // Scoreboard: each accepted result must match the oldest expected value.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            hs_cnt++;
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: result %0h accepted with none expected", res);
            end else begin
                sb_exp = sb.pop_front();
                if (res !== sb_exp) begin
                    n_err++;
                    $display("FAIL sb_res: got %0h, expected %0h", res, sb_exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] fair_exp [4];
        logic [3:0] ld_exp [4];
        logic       ok;

        // ---------------- reset ----------------
        step();
        step();
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_opnd", 32'(opnd), 32'h0);
        chk("rst_res", 32'(res), 32'h0);
        chk("rst_rv", 32'(res_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_cnt", 32'(done_cnt), 32'h0);
        rst = 1'b0;

        // ---------------- full load, table driven ----------------
        //            req      mask     rdy   ack      busy  rv
        tbl[0] = '{4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b0, 1'b0};
        tbl[1] = '{4'b1111, 4'b1111, 1'b0, 4'b0010, 1'b0, 1'b0};
        tbl[2] = '{4'b1110, 4'b1111, 1'b0, 4'b0100, 1'b0, 1'b0};
        tbl[3] = '{4'b1100, 4'b1111, 1'b0, 4'b1000, 1'b0, 1'b0};
        tbl[4] = '{4'b1000, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b0};
        tbl[5] = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b0};
        tbl[6] = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1};
        tbl[7] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0};
        tbl[8] = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0};
        req_data = 16'h4321;
        blk_res  = 4'hA;
        sb.push_back(4'hA);
        for (int i = 0; i < 9; i++) begin
            req       = tbl[i].req;
            slot_mask = tbl[i].mask;
            res_ready = tbl[i].rdy;
            step();
            chk($sformatf("full_ack[%0d]", i), 32'(ack), 32'(tbl[i].e_ack));
            chk($sformatf("full_busy[%0d]", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("full_rv[%0d]", i), 32'(res_valid), 32'(tbl[i].e_rv));
            if (tbl[i].e_rv) chk($sformatf("full_res[%0d]", i), 32'(res), 32'hA);
            if (i == 3 || i == 5) chk($sformatf("full_opnd[%0d]", i), 32'(opnd), 32'h4321);
        end
        chk("full_cnt", 32'(done_cnt), 32'(exp_done()));

        // ---------------- partial mask 0011 ----------------
        req       = 4'b0011;
        req_data  = 16'h0065;
        slot_mask = 4'b0011;
        blk_res   = 4'hB;
        res_ready = 1'b1;
        sb.push_back(4'hB);
        step(); chk("part_ack0", 32'(ack), 32'h1);
        step(); chk("part_ack1", 32'(ack), 32'h2);
        req = 4'b0000;
        step(); chk("part_busy", 32'(busy), 32'h1);
        step(); chk("part_rv_early", 32'(res_valid), 32'h0);
        step(); chk("part_rv", 32'(res_valid), 32'h1);
        chk("part_res", 32'(res), 32'hB);
        step(); chk("part_rv_clr", 32'(res_valid), 32'h0);
        chk("part_busy_clr", 32'(busy), 32'h0);
        chk("part_opnd", 32'(opnd[7:0]), 32'h65);
        res_ready = 1'b0;

        // ---------------- fairness from rr_ptr=2, then backpressure ----------------
        fair_exp = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
        req       = 4'b1111;
        req_data  = 16'hDCBA;
        slot_mask = 4'b1111;
        blk_res   = 4'h3;
        sb.push_back(4'h3);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("fair_ack[%0d]", k), 32'(ack), 32'(fair_exp[k]));
        end
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("fair_noack[%0d]", k), 32'(ack), 32'h0);
            chk($sformatf("fair_rv[%0d]", k), 32'(res_valid), (k == 2) ? 32'h1 : 32'h0);
        end
        chk("fair_res", 32'(res), 32'h3);
        blk_res = 4'h9;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("bp_rv[%0d]", k), 32'(res_valid), 32'h1);
            chk($sformatf("bp_res[%0d]", k), 32'(res), 32'h3);
            chk($sformatf("bp_ack[%0d]", k), 32'(ack), 32'h0);
            chk($sformatf("bp_opnd[%0d]", k), 32'(opnd), 32'hDCBA);
        end
        res_ready = 1'b1;
        step();
        chk("bp_rv_clr", 32'(res_valid), 32'h0);
        chk("bp_busy_clr", 32'(busy), 32'h0);
        chk("bp_ack_h1", 32'(ack), 32'h0);
        chk("bp_cnt", 32'(done_cnt), 32'(exp_done()));
        step();
        chk("bp_ack_h2", 32'(ack), 32'h4);

        // ---------------- partial mask with slot 2 already filled ----------------
        res_ready = 1'b0;
        req       = 4'b0011;
        req_data  = 16'hDC21;
        slot_mask = 4'b0011;
        blk_res   = 4'h7;
        sb.push_back(4'h7);
        step(); chk("ret_ack0", 32'(ack), 32'h1);
        step(); chk("ret_ack1", 32'(ack), 32'h2);
        req = 4'b0000;
        step(); chk("ret_busy", 32'(busy), 32'h1);
        step();
        step(); chk("ret_rv", 32'(res_valid), 32'h1);
        chk("ret_res", 32'(res), 32'h7);
        res_ready = 1'b1;
        step(); chk("ret_rv_clr", 32'(res_valid), 32'h0);
        chk("ret_opnd", 32'(opnd), 32'hDC21);
        res_ready = 1'b0;
        req       = 4'b0100;
        req_data  = 16'h0500;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("ret_noack[%0d]", k), 32'(ack), 32'h0);
            chk($sformatf("ret_slot2[%0d]", k), 32'(opnd[11:8]), 32'hC);
            chk($sformatf("ret_idle[%0d]", k), 32'(busy), 32'h0);
        end

        // ---------------- reset mid-WAIT ----------------
        req       = 4'b0000;
        slot_mask = 4'b0100;
        step(); chk("abort_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        step();
        hs_base = hs_cnt;
        chk("abort_ack", 32'(ack), 32'h0);
        chk("abort_opnd", 32'(opnd), 32'h0);
        chk("abort_res", 32'(res), 32'h0);
        chk("abort_rv", 32'(res_valid), 32'h0);
        chk("abort_busy0", 32'(busy), 32'h0);
        chk("abort_cnt", 32'(done_cnt), 32'h0);
        rst       = 1'b0;
        slot_mask = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("abort_norv[%0d]", k), 32'(res_valid), 32'h0);
            chk($sformatf("abort_idle[%0d]", k), 32'(busy), 32'h0);
        end

        // ---------------- mask=0 never launches ----------------
        ld_exp    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        req       = 4'b1111;
        req_data  = 16'h4321;
        slot_mask = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("m0_ack[%0d]", k), 32'(ack), 32'(ld_exp[k]));
        end
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("m0_busy[%0d]", k), 32'(busy), 32'h0);
            chk($sformatf("m0_ack0[%0d]", k), 32'(ack), 32'h0);
        end
        chk("m0_opnd", 32'(opnd), 32'h4321);
        chk("m0_cnt", 32'(done_cnt), 32'(exp_done()));

`ifdef BLKSCHED_COUNT_EN
        // ---------------- 256 handshakes wrap the counter ----------------
        req       = 4'b0001;
        slot_mask = 4'b0001;
        res_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            blk_res = 4'(i);
            sb.push_back(4'(i));
            ok = 1'b0;
            for (int t = 0; t < 20 && !ok; t++) begin
                step();
                if (res_valid) ok = 1'b1;
            end
            chk($sformatf("wrap_rv[%0d]", i), 32'(ok), 32'h1);
            step();
            chk($sformatf("wrap_cnt[%0d]", i), 32'(done_cnt), 32'(exp_done()));
        end
        chk("wrap_zero", 32'(done_cnt), 32'h0);
        req       = 4'b0000;
        res_ready = 1'b0;
`else
        ok = 1'b0;
`endif

        step();
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_blk_operand_sched
